mem_stage: RTL and testbench

- Memory-access pipeline stage between the execute stage and write-back.
- Takes the execute stage's control bits, ALU result (address) and store data, and drives a single-outstanding data-memory bus with a req/ready handshake.
- Formats load data (byte/half/word, signed/unsigned) and produces the MEM/WB pipeline register.
- Requests a pipeline stall while a bus access is in flight; reports misaligned accesses and bus timeouts.

---
 rtl/mem_stage.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a single-outstanding data bus, formats
// load data and produces the MEM/WB register, with misalignment and timeout reporting.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_RegWrite,
  input  logic [4:0]  in_RegDest,
  input  logic        in_MemToReg,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_result,
  input  logic [31:0] in_rs2_value,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_RegDest,
  output logic        wb_MemToReg,
  output logic [31:0] wb_data_out,
  output logic [31:0] wb_AluResult,
  output logic        misaligned,
  output logic        bus_error,
  output logic [31:0] err_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              lat_we_q;
  logic              lat_rw_q;
  logic [4:0]        lat_rd_q;
  logic              lat_m2r_q;
  logic [2:0]        lat_f3_q;
  logic [31:0]       lat_addr_q;

  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [31:0]       dmem_addr_q;
  logic [31:0]       dmem_wdata_q;
  logic [3:0]        dmem_wstrb_q;
  logic              wb_rw_q;
  logic [4:0]        wb_rd_q;
  logic              wb_m2r_q;
  logic [31:0]       wb_data_q;
  logic [31:0]       wb_alu_q;
  logic              misaligned_q;
  logic              bus_error_q;
  logic [31:0]       err_addr_q;

  logic              is_mem_d;
  logic              misalign_d;
  logic [3:0]        st_wstrb_d;
  logic [31:0]       st_wdata_d;
  logic [7:0]        ld_byte_d;
  logic [15:0]       ld_half_d;
  logic [31:0]       ld_data_d;

  // Access decode on the incoming instruction; funct3[1:0] 00=B, 01=H, else W.
  always_comb begin
    is_mem_d   = in_MemRead | in_MemWrite;
    misalign_d = 1'b0;
    st_wstrb_d = 4'b1111;
    st_wdata_d = in_rs2_value;
    unique case (in_funct3[1:0])
      2'b00: begin
        st_wstrb_d = 4'(4'b0001 << in_result[1:0]);
        st_wdata_d = {4{in_rs2_value[7:0]}};
      end
      2'b01: begin
        misalign_d = in_result[0];
        st_wstrb_d = in_result[1] ? 4'b1100 : 4'b0011;
        st_wdata_d = {2{in_rs2_value[15:0]}};
      end
      default: begin
        misalign_d = (in_result[1:0] != 2'b00);
      end
    endcase
  end

  // Load lane selection and sign/zero extension from the latched access.
  always_comb begin
    ld_byte_d = dmem_rdata[7:0];
    unique case (lat_addr_q[1:0])
      2'b00: ld_byte_d = dmem_rdata[7:0];
      2'b01: ld_byte_d = dmem_rdata[15:8];
      2'b10: ld_byte_d = dmem_rdata[23:16];
      2'b11: ld_byte_d = dmem_rdata[31:24];
    endcase
    ld_half_d = lat_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (lat_f3_q[1:0])
      2'b00:   ld_data_d = {{24{ld_byte_d[7] & ~lat_f3_q[2]}}, ld_byte_d};
      2'b01:   ld_data_d = {{16{ld_half_d[15] & ~lat_f3_q[2]}}, ld_half_d};
      default: ld_data_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lat_we_q     <= 1'b0;
      lat_rw_q     <= 1'b0;
      lat_rd_q     <= '0;
      lat_m2r_q    <= 1'b0;
      lat_f3_q     <= '0;
      lat_addr_q   <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
      wb_rw_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_m2r_q     <= 1'b0;
      wb_data_q    <= '0;
      wb_alu_q     <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!is_mem_d) begin
            wb_rw_q   <= in_RegWrite;
            wb_rd_q   <= in_RegDest;
            wb_m2r_q  <= in_MemToReg;
            wb_alu_q  <= in_result;
            wb_data_q <= '0;
          end else if (misalign_d) begin
            misaligned_q <= 1'b1;
            err_addr_q   <= in_result;
            wb_rw_q      <= 1'b0;
          end else begin
            lat_we_q     <= in_MemWrite;
            lat_rw_q     <= in_RegWrite;
            lat_rd_q     <= in_RegDest;
            lat_m2r_q    <= in_MemToReg;
            lat_f3_q     <= in_funct3;
            lat_addr_q   <= in_result;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= in_MemWrite;
            dmem_addr_q  <= {in_result[31:2], 2'b00};
            dmem_wstrb_q <= in_MemWrite ? st_wstrb_d : 4'b0000;
            if (in_MemWrite) begin
              dmem_wdata_q <= st_wdata_d;
            end
            cnt_q        <= '0;
            wb_rw_q      <= 1'b0;
            state_q      <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ready takes priority over a timeout landing on the same cycle.
          if (dmem_ready) begin
            dmem_req_q <= 1'b0;
            if (!lat_we_q) begin
              wb_data_q <= ld_data_d;
            end
            wb_rw_q  <= lat_rw_q & ~lat_we_q;
            wb_rd_q  <= lat_rd_q;
            wb_m2r_q <= lat_m2r_q;
            wb_alu_q <= lat_addr_q;
            state_q  <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            dmem_req_q  <= 1'b0;
            bus_error_q <= 1'b1;
            err_addr_q  <= lat_addr_q;
            wb_rw_q     <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign stall_req    = (state_q == ST_BUS);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_wstrb   = dmem_wstrb_q;
  assign wb_RegWrite  = wb_rw_q;
  assign wb_RegDest   = wb_rd_q;
  assign wb_MemToReg  = wb_m2r_q;
  assign wb_data_out  = wb_data_q;
  assign wb_AluResult = wb_alu_q;
  assign misaligned   = misaligned_q;
  assign bus_error    = bus_error_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, loads, stores, misalignment,
// timeout, ready-at-timeout and mid-access reset.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_MemWrite;
  logic        in_MemRead;
  logic        in_RegWrite;
  logic [4:0]  in_RegDest;
  logic        in_MemToReg;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic [31:0] in_rs2_value;
  logic        stall_req;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        wb_RegWrite;
  logic [4:0]  wb_RegDest;
  logic        wb_MemToReg;
  logic [31:0] wb_data_out;
  logic [31:0] wb_AluResult;
  logic        misaligned;
  logic        bus_error;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_RegWrite(in_RegWrite),
    .in_RegDest(in_RegDest), .in_MemToReg(in_MemToReg), .in_funct3(in_funct3),
    .in_result(in_result), .in_rs2_value(in_rs2_value),
    .stall_req(stall_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .wb_RegWrite(wb_RegWrite), .wb_RegDest(wb_RegDest), .wb_MemToReg(wb_MemToReg),
    .wb_data_out(wb_data_out), .wb_AluResult(wb_AluResult),
    .misaligned(misaligned), .bus_error(bus_error), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic we, input logic rd, input logic rw, input logic [4:0] dst,
                        input logic m2r, input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] rs2);
    in_MemWrite  = we;
    in_MemRead   = rd;
    in_RegWrite  = rw;
    in_RegDest   = dst;
    in_MemToReg  = m2r;
    in_funct3    = f3;
    in_result    = res;
    in_rs2_value = rs2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
    repeat (2) tick();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", dmem_req); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_req); end
    checks++; if (wb_RegWrite !== 1'b0) begin errors++; $display("FAIL rst_wb_rw got %b exp 0", wb_RegWrite); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL rst_err_addr got %h exp 0", err_addr); end
    checks++; if ({misaligned, bus_error} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {misaligned, bus_error}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    set_in(0, 0, 1, 5'd5, 0, 3'b000, 32'h1234, 32'h0);
    tick();
    checks++; if (wb_RegWrite !== 1'b1) begin errors++; $display("FAIL add_rw got %b exp 1", wb_RegWrite); end
    checks++; if (wb_RegDest !== 5'd5) begin errors++; $display("FAIL add_rd got %0d exp 5", wb_RegDest); end
    checks++; if (wb_AluResult !== 32'h1234) begin errors++; $display("FAIL add_alu got %h exp 00001234", wb_AluResult); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL add_req got %b exp 0", dmem_req); end
    checks++; if (wb_data_out !== 32'h0) begin errors++; $display("FAIL add_data got %h exp 0", wb_data_out); end
    @(negedge clk);
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_load_byte(input bit uns);
    logic [31:0] exp;
    int stall_cycles;
    exp = uns ? 32'h0000_0080 : 32'hFFFF_FF80;
    stall_cycles = 0;
    @(negedge clk);
    set_in(0, 0, 1, 5'd2, 0, 3'b000, 32'hABCD, 32'h0);
    @(negedge clk);
    set_in(0, 1, 1, 5'd7, 1, uns ? 3'b100 : 3'b000, 32'h103, 32'h0);
    tick();
    if (stall_req === 1'b1) stall_cycles++;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("FAIL lb_req got req=%b we=%b exp req=1 we=0", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", dmem_addr); end
    checks++; if (dmem_wstrb !== 4'b0000) begin errors++; $display("FAIL lb_wstrb got %b exp 0000", dmem_wstrb); end
    checks++; if (wb_RegWrite !== 1'b0 || wb_AluResult !== 32'hABCD) begin errors++; $display("FAIL lb_bubble got rw=%b alu=%h exp rw=0 alu=0000abcd", wb_RegWrite, wb_AluResult); end
    repeat (2) begin
      tick();
      if (stall_req === 1'b1) stall_cycles++;
    end
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin errors++; $display("FAIL lb_hold got req=%b addr=%h exp req=1 addr=00000100", dmem_req, dmem_addr); end
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF_FF00;
    tick();
    if (stall_req === 1'b1) stall_cycles++;
    checks++; if (stall_cycles != 3) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 3", stall_cycles); end
    checks++; if (wb_data_out !== exp) begin errors++; $display("FAIL lb_data got %h exp %h", wb_data_out, exp); end
    checks++; if (wb_RegWrite !== 1'b1 || wb_RegDest !== 5'd7 || wb_MemToReg !== 1'b1) begin errors++; $display("FAIL lb_wb_ctrl got rw=%b rd=%0d m2r=%b exp 1 7 1", wb_RegWrite, wb_RegDest, wb_MemToReg); end
    checks++; if (wb_AluResult !== 32'h103 || dmem_req !== 1'b0) begin errors++; $display("FAIL lb_done got alu=%h req=%b exp 00000103 0", wb_AluResult, dmem_req); end
    @(negedge clk);
    dmem_ready = 1'b0;
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    @(negedge clk);
    set_in(1, 0, 1, 5'd9, 0, f3, addr, rs2);
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL st_req got req=%b we=%b exp 1 1", dmem_req, dmem_we); end
    checks++; if (dmem_wstrb !== exp_strb) begin errors++; $display("FAIL st_wstrb got %b exp %b", dmem_wstrb, exp_strb); end
    checks++; if (dmem_wdata !== exp_wdata) begin errors++; $display("FAIL st_wdata got %h exp %h", dmem_wdata, exp_wdata); end
    checks++; if (dmem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL st_addr got %h exp %h", dmem_addr, {addr[31:2], 2'b00}); end
    @(negedge clk);
    dmem_ready = 1'b1;
    tick();
    checks++; if (wb_RegWrite !== 1'b0 || stall_req !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL st_done got rw=%b stall=%b req=%b exp 000", wb_RegWrite, stall_req, dmem_req); end
    checks++; if (dmem_addr !== {addr[31:2], 2'b00} || wb_AluResult !== addr) begin errors++; $display("FAIL st_held got addr=%h alu=%h exp %h %h", dmem_addr, wb_AluResult, {addr[31:2], 2'b00}, addr); end
    @(negedge clk);
    dmem_ready = 1'b0;
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    set_in(0, 0, 1, 5'd4, 0, 3'b000, 32'h77, 32'h0);
    @(negedge clk);
    set_in(0, 1, 1, 5'd6, 1, 3'b010, 32'h305, 32'h0);
    tick();
    checks++; if (misaligned !== 1'b1 || err_addr !== 32'h305) begin errors++; $display("FAIL mis_pulse got mis=%b err=%h exp 1 00000305", misaligned, err_addr); end
    checks++; if (dmem_req !== 1'b0 || stall_req !== 1'b0 || wb_RegWrite !== 1'b0) begin errors++; $display("FAIL mis_nobus got req=%b stall=%b rw=%b exp 000", dmem_req, stall_req, wb_RegWrite); end
    @(negedge clk);
    set_in(0, 0, 1, 5'd9, 0, 3'b000, 32'h55, 32'h0);
    tick();
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %b exp 0", misaligned); end
    checks++; if (wb_RegWrite !== 1'b1 || wb_RegDest !== 5'd9 || wb_AluResult !== 32'h55) begin errors++; $display("FAIL mis_next got rw=%b rd=%0d alu=%h exp 1 9 00000055", wb_RegWrite, wb_RegDest, wb_AluResult); end
    @(negedge clk);
    set_in(1, 0, 0, 5'd0, 0, 3'b001, 32'h203, 32'h0);
    tick();
    checks++; if (misaligned !== 1'b1 || dmem_req !== 1'b0 || err_addr !== 32'h203) begin errors++; $display("FAIL mis_sh got mis=%b req=%b err=%h exp 1 0 00000203", misaligned, dmem_req, err_addr); end
    @(negedge clk);
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    @(negedge clk);
    set_in(0, 1, 1, 5'd3, 1, 3'b010, 32'h400, 32'h0);
    tick();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL to_req got %b exp 1", dmem_req); end
    for (int i = 1; i < 16; i++) begin
      tick();
      if (bus_error !== 1'b0 || stall_req !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", early); end
    tick();
    checks++; if (bus_error !== 1'b1 || err_addr !== 32'h400) begin errors++; $display("FAIL to_pulse got berr=%b err=%h exp 1 00000400", bus_error, err_addr); end
    checks++; if (stall_req !== 1'b0 || dmem_req !== 1'b0 || wb_RegWrite !== 1'b0) begin errors++; $display("FAIL to_abort got stall=%b req=%b rw=%b exp 000", stall_req, dmem_req, wb_RegWrite); end
    @(negedge clk);
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
    tick();
    checks++; if (bus_error !== 1'b0 || err_addr !== 32'h400) begin errors++; $display("FAIL to_after got berr=%b err=%h exp 0 00000400", bus_error, err_addr); end
  endtask

  task automatic test_ready_at_timeout;
    @(negedge clk);
    set_in(0, 1, 1, 5'd8, 1, 3'b010, 32'h500, 32'h0);
    tick();
    repeat (15) tick();
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (bus_error !== 1'b0 || wb_RegWrite !== 1'b1) begin errors++; $display("FAIL rat_win got berr=%b rw=%b exp 0 1", bus_error, wb_RegWrite); end
    checks++; if (wb_data_out !== 32'hDEAD_BEEF || err_addr !== 32'h400) begin errors++; $display("FAIL rat_data got data=%h err=%h exp deadbeef 00000400", wb_data_out, err_addr); end
    @(negedge clk);
    dmem_ready = 1'b0;
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_bus;
    @(negedge clk);
    set_in(0, 0, 1, 5'd1, 1, 3'b000, 32'h99, 32'h0);
    @(negedge clk);
    set_in(0, 1, 1, 5'd3, 1, 3'b010, 32'h600, 32'h0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL mrst_bus got req=%b stall=%b exp 0 0", dmem_req, stall_req); end
    checks++; if ({wb_RegWrite, wb_MemToReg, wb_RegDest} !== 7'd0 || wb_AluResult !== 32'h0 || err_addr !== 32'h0) begin errors++; $display("FAIL mrst_wb got rw=%b m2r=%b rd=%0d alu=%h err=%h exp all 0", wb_RegWrite, wb_MemToReg, wb_RegDest, wb_AluResult, err_addr); end
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 1, 1, 5'd3, 1, 3'b001, 32'h0, 32'h0);
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0) begin errors++; $display("FAIL lh_req got req=%b addr=%h exp 1 00000000", dmem_req, dmem_addr); end
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0000_8001;
    tick();
    checks++; if (wb_data_out !== 32'hFFFF_8001 || wb_RegWrite !== 1'b1) begin errors++; $display("FAIL lh_data got data=%h rw=%b exp ffff8001 1", wb_data_out, wb_RegWrite); end
    @(negedge clk);
    dmem_ready = 1'b0;
    set_in(0, 1, 1, 5'd3, 1, 3'b101, 32'h2, 32'h0);
    tick();
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h8001_0000;
    tick();
    checks++; if (wb_data_out !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", wb_data_out); end
    @(negedge clk);
    dmem_ready = 1'b0;
    set_in(0, 0, 0, 5'd0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte(1'b0);
    test_load_byte(1'b1);
    test_store(3'b001, 32'h202, 32'hCAFE_BEEF, 4'b1100, 32'hBEEF_BEEF);
    test_store(3'b000, 32'h001, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    test_store(3'b010, 32'h010, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    test_misaligned();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
